riscv_lsu: RTL and testbench
============================

# riscv_lsu

Parametrised load/store unit between the pipeline's Memory stage and a handshaked data-memory bus. It replaces the fixed single-cycle dmem port with a request/ready bus that tolerates wait states, generates byte strobes, sign/zero-extends loads, flags misaligned or illegal accesses, and bounds every transaction with a timeout. While a transfer is outstanding it raises `stallM`; the hazard unit ORs this into its stall/flush logic to freeze F, D, E and M.

## Interface
- `XLEN`, 32: data width; legal values 32 and 64.
- `ADDR_W`, 32: bus address width.
- `TIMEOUT`, 255: max cycles in BUSY before a bus error; ≥ 1.

- `clk`  in  1  clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `memreadM`  in  1  M-stage instruction is a load.
- `memwriteM`  in  1  M-stage instruction is a store; never high together with `memreadM`.
- `funct3M`  in  3  access width/signedness.
- `addrM`  in  XLEN  byte address (ALU result).
- `writedataM`  in  XLEN  store data, right-aligned.
- `readdataM`  out  XLEN  extended load data, to M/W register.
- `stallM`  out  1  pipeline freeze request.
- `misalignM`  out  1  misaligned/illegal access, single-cycle flag.
- `buserrM`  out  1  timeout flag, single-cycle pulse.
- `bus_req`  out  1  transfer request.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  ADDR_W  XLEN/8-aligned address.
- `bus_be`  out  XLEN/8  byte enables.
- `bus_wdata`  out  XLEN  lane-shifted store data.
- `bus_ready`  in  1  bus completes transfer this cycle.
- `bus_rdata`  in  XLEN  read data, valid when `bus_ready`.

## Operation
- funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; with XLEN=64 also 011 D, 110 WU. Any other code is illegal.
- Misaligned: H with addr[0]≠0; W with addr[1:0]≠0; D with addr[2:0]≠0. Misaligned or illegal → `misalignM`=1 combinationally in IDLE, no bus transfer, no stall, store suppressed, `readdataM` unchanged.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: legal access → `stallM`=1 combinationally; next BUSY, latching we, aligned address, `bus_be`, `bus_wdata`, funct3, byte offset.
  - BUSY: `bus_req`=1, bus outputs stable, `stallM`=1, cycle counter increments. `bus_ready` → capture extended `bus_rdata` (loads) into `readdataM`, next DONE. Counter reaches `TIMEOUT` without ready → `buserrM` pulse, `readdataM`=0, next DONE.
  - DONE: `stallM`=0, `bus_req`=0; pipeline advances; next IDLE unconditionally (new M instruction evaluated in IDLE).
- Byte lanes: `bus_be` = width mask (1, 3, 0xF, 0xFF) shifted left by addr[log2(XLEN/8)-1:0]; `bus_wdata` = `writedataM` shifted left by 8×offset.
- Loads: shift `bus_rdata` right by 8×offset, truncate to width, sign-extend (B/H/W) or zero-extend (BU/HU/WU); D passes through.
- `readdataM` holds last value until next load completes; stores never modify it.
- `bus_ready` outside BUSY is ignored.

## Timing
- Reset (asserted, async): state IDLE, counter 0, `readdataM`=0, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_be`=0, `bus_wdata`=0, `buserrM`=0. `stallM`/`misalignM` are combinational from IDLE + inputs. Reset mid-BUSY drops `bus_req` immediately; transfer abandoned.
- Zero-wait transfer (ready in first BUSY cycle): stall cycles = 2 (IDLE, BUSY), DONE cycle third; `readdataM` valid from DONE.
- N wait states: stall cycles = 2+N.
- Timeout: `buserrM` high in the cycle after the `TIMEOUT`-th BUSY cycle, i.e. coincident with DONE.
- Back-to-back accesses: minimum spacing one transfer per 3 cycles.

## Structure
- `lsu_pkg`: state enum (IDLE/BUSY/DONE), funct3 width constants, `be_mask` and `is_legal` functions.
- Sub-module `lsu_align`: combinational lane steering, byte-enable generation, load extension, misalign detection; `riscv_lsu` holds FSM, counter and registers.

## Test plan
- LW at 0x100, `bus_ready` on first BUSY cycle, rdata 0xDEADBEEF → `stallM` 2 cycles, `readdataM`=0xDEADBEEF in DONE.
- LB at 0x103, rdata 0x80112233 → `bus_addr`=0x100, `readdataM`=0xFFFFFF80; LBU same → 0x00000080.
- SH at 0x102, data 0x0000ABCD, 3 wait states → `bus_be`=0b1100, `bus_wdata`=0xABCD0000, `stallM` 5 cycles, `readdataM` unchanged.
- LW at 0x101 → `misalignM`=1 one cycle, `bus_req` never rises, `stallM`=0; funct3=111 same result.
- TIMEOUT=4, `bus_ready` held 0 → `buserrM` pulse with DONE, `readdataM`=0, state IDLE after.
- Reset asserted in 2nd BUSY cycle → `bus_req`=0 same cycle, all registers at reset values; next LW after release completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and access-width helpers for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  function automatic logic [7:0] be_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      2'b10:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] f3, input logic wide);
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: return 1'b1;
      F3_D, F3_WU:                    return wide;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane steering, byte enables, load extension and misalign detection
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic [2:0]        addr_lo_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN/8-1:0] be_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic              misalign_o,
  input  logic [2:0]        ld_funct3_i,
  input  logic [2:0]        ld_off_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [XLEN-1:0]   ld_data_o
);

  localparam int NB = XLEN / 8;
  localparam logic [2:0] OFF_MASK = 3'(NB - 1);

  logic [2:0]      off;
  logic [2:0]      ld_off;
  logic [3:0]      size_bytes;
  logic [2:0]      size_mask;
  logic [15:0]     be_wide;
  logic [XLEN-1:0] rshift;
  logic [6:0]      nbits;
  logic            sign;

  // Offset within the bus word; higher address bits only select the word.
  assign off        = addr_lo_i & OFF_MASK;
  assign ld_off     = ld_off_i & OFF_MASK;

  assign size_bytes = 4'd1 << funct3_i[1:0];
  assign size_mask  = 3'(size_bytes - 4'd1);
  assign misalign_o = !is_legal(funct3_i, XLEN == 64) || ((addr_lo_i & size_mask) != 3'd0);

  assign be_wide    = {8'h00, be_mask(funct3_i)} << off;
  assign be_o       = be_wide[NB-1:0];
  assign wdata_o    = wdata_i << {off, 3'b000};

  assign rshift     = rdata_i >> {ld_off, 3'b000};

  always_comb begin
    nbits     = 7'd8 << ld_funct3_i[1:0];
    sign      = 1'b0;
    ld_data_o = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (i == int'(nbits) - 1) sign = rshift[i] & ~ld_funct3_i[2];
    end
    for (int i = 0; i < XLEN; i++) begin
      ld_data_o[i] = (i < int'(nbits)) ? rshift[i] : sign;
    end
  end

endmodule

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - load/store unit bridging the M stage to a ready-handshaked data bus
module riscv_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memreadM,
  input  logic              memwriteM,
  input  logic [2:0]        funct3M,
  input  logic [XLEN-1:0]   addrM,
  input  logic [XLEN-1:0]   writedataM,
  output logic [XLEN-1:0]   readdataM,
  output logic              stallM,
  output logic              misalignM,
  output logic              buserrM,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [XLEN/8-1:0] bus_be,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic              bus_ready,
  input  logic [XLEN-1:0]   bus_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   readdata_q;
  logic [XLEN-1:0]   wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [NB-1:0]     be_q;
  logic [2:0]        f3_q;
  logic [2:0]        off_q;
  logic              req_q;
  logic              we_q;
  logic              buserr_q;

  logic              access;
  logic              misal;
  logic              start;
  logic [NB-1:0]     be_c;
  logic [XLEN-1:0]   wdata_c;
  logic [XLEN-1:0]   ld_data;
  logic [ADDR_W-1:0] addr_al;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3_i    (funct3M),
    .addr_lo_i   (addrM[2:0]),
    .wdata_i     (writedataM),
    .be_o        (be_c),
    .wdata_o     (wdata_c),
    .misalign_o  (misal),
    .ld_funct3_i (f3_q),
    .ld_off_i    (off_q),
    .rdata_i     (bus_rdata),
    .ld_data_o   (ld_data)
  );

  assign access    = memreadM | memwriteM;
  assign misalignM = (state_q == ST_IDLE) && access && misal;
  assign start     = (state_q == ST_IDLE) && access && !misal;
  assign stallM    = start || (state_q == ST_BUSY);
  assign addr_al   = {addrM[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  assign readdataM = readdata_q;
  assign buserrM   = buserr_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      readdata_q <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      be_q       <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      buserr_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_BUSY;
            req_q   <= 1'b1;
            we_q    <= memwriteM;
            addr_q  <= addr_al;
            be_q    <= be_c;
            wdata_q <= wdata_c;
            f3_q    <= funct3M;
            off_q   <= addrM[2:0];
            cnt_q   <= '0;
          end
        end
        ST_BUSY: begin
          if (bus_ready) begin
            state_q <= ST_DONE;
            req_q   <= 1'b0;
            if (!we_q) readdata_q <= ld_data;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // A store that times out leaves the load result register untouched.
            state_q  <= ST_DONE;
            req_q    <= 1'b0;
            buserr_q <= 1'b1;
            if (!we_q) readdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_q  <= ST_IDLE;
          buserr_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - directed self-checking bench for riscv_lsu
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memreadM = 1'b0;
  logic        memwriteM = 1'b0;
  logic [2:0]  funct3M = 3'b000;
  logic [31:0] addrM = '0;
  logic [31:0] writedataM = '0;
  logic [31:0] readdataM;
  logic        stallM;
  logic        misalignM;
  logic        buserrM;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;

  always #5 clk = ~clk;

  riscv_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .memreadM   (memreadM),
    .memwriteM  (memwriteM),
    .funct3M    (funct3M),
    .addrM      (addrM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .stallM     (stallM),
    .misalignM  (misalignM),
    .buserrM    (buserrM),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  int          stalls;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;
  logic        saw_req;
  logic        unstable;
  logic        first_misal;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge with the DUT in IDLE; returns in the first non-stalled cycle.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdat, input int waits);
    int busy = 0;
    bit done = 0;
    memreadM = rd; memwriteM = wr; funct3M = f3; addrM = addr;
    writedataM = wd; bus_rdata = rdat; bus_ready = 1'b0;
    stalls = 0; saw_req = 1'b0; unstable = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (c == 0) first_misal = misalignM;
      if (bus_req) begin
        if (!saw_req) begin
          cap_addr = bus_addr; cap_be = bus_be; cap_wdata = bus_wdata; cap_we = bus_we;
          saw_req = 1'b1;
        end else if (bus_addr !== cap_addr || bus_be !== cap_be ||
                     bus_wdata !== cap_wdata || bus_we !== cap_we) begin
          unstable = 1'b1;
        end
        bus_ready = (busy == waits);
        busy++;
      end else begin
        bus_ready = 1'b0;
      end
      if (stallM) begin
        stalls++;
        @(negedge clk);
      end else begin
        done = 1;
      end
    end
    check("access_bound", done, 1);
    memreadM = 1'b0; memwriteM = 1'b0; bus_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_readdata", readdataM, 32'h0);
    check("rst_req", bus_req, 1'b0);
    check("rst_we", bus_we, 1'b0);
    check("rst_addr", bus_addr, 32'h0);
    check("rst_be", bus_be, 4'h0);
    check("rst_wdata", bus_wdata, 32'h0);
    check("rst_buserr", buserrM, 1'b0);
    check("rst_stall", stallM, 1'b0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    check("lw_misal", first_misal, 1'b0);
    check("lw_stalls", stalls, 2);
    check("lw_data", readdataM, 32'hDEADBEEF);
    check("lw_addr", cap_addr, 32'h100);
    check("lw_be", cap_be, 4'hF);
    check("lw_we", cap_we, 1'b0);
    check("lw_done_req", bus_req, 1'b0);
    @(negedge clk);

    access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0);
    check("lb_addr", cap_addr, 32'h100);
    check("lb_be", cap_be, 4'h8);
    check("lb_data", readdataM, 32'hFFFFFF80);
    @(negedge clk);

    access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0);
    check("lbu_data", readdataM, 32'h00000080);
    @(negedge clk);

    access(1, 0, 3'b001, 32'h102, 32'h0, 32'h80112233, 1);
    check("lh_stalls", stalls, 3);
    check("lh_be", cap_be, 4'hC);
    check("lh_data", readdataM, 32'hFFFF8011);
    @(negedge clk);

    access(1, 0, 3'b101, 32'h102, 32'h0, 32'h80112233, 0);
    check("lhu_data", readdataM, 32'h00008011);
    @(negedge clk);

    access(1, 0, 3'b000, 32'h106, 32'h0, 32'h00AB0000, 0);
    check("lb_hi_addr", cap_addr, 32'h104);
    check("lb_hi_be", cap_be, 4'h4);
    check("lb_hi_data", readdataM, 32'hFFFFFFAB);
    @(negedge clk);

    access(1, 0, 3'b101, 32'h102, 32'h0, 32'h80112233, 0);
    @(negedge clk);

    access(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 32'hFFFFFFFF, 3);
    check("sh_stalls", stalls, 5);
    check("sh_be", cap_be, 4'hC);
    check("sh_wdata", cap_wdata, 32'hABCD0000);
    check("sh_we", cap_we, 1'b1);
    check("sh_stable", unstable, 1'b0);
    check("sh_keep_rd", readdataM, 32'h00008011);
    @(negedge clk);

    access(0, 1, 3'b000, 32'h101, 32'h000000EE, 32'h0, 0);
    check("sb_addr", cap_addr, 32'h100);
    check("sb_be", cap_be, 4'h2);
    check("sb_wdata", cap_wdata, 32'h0000EE00);
    @(negedge clk);

    access(0, 1, 3'b010, 32'h104, 32'h12345678, 32'h0, 0);
    check("sw_addr", cap_addr, 32'h104);
    check("sw_be", cap_be, 4'hF);
    check("sw_wdata", cap_wdata, 32'h12345678);
    check("sw_keep_rd", readdataM, 32'h00008011);
    @(negedge clk);

    access(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
    check("mis_lw_flag", first_misal, 1'b1);
    check("mis_lw_stall", stalls, 0);
    check("mis_lw_req", saw_req, 1'b0);
    @(negedge clk); #1;
    check("mis_lw_pulse", misalignM, 1'b0);
    check("mis_lw_req2", bus_req, 1'b0);
    check("mis_lw_keep", readdataM, 32'h00008011);
    @(negedge clk);

    access(1, 0, 3'b111, 32'h100, 32'h0, 32'h0, 0);
    check("ill_111_flag", first_misal, 1'b1);
    check("ill_111_req", saw_req, 1'b0);
    @(negedge clk);

    access(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    check("ill_d32_flag", first_misal, 1'b1);
    @(negedge clk);

    access(0, 1, 3'b001, 32'h103, 32'hFFFF, 32'h0, 0);
    check("mis_sh_flag", first_misal, 1'b1);
    check("mis_sh_req", saw_req, 1'b0);
    @(negedge clk);

    bus_ready = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk); #1;
    check("idle_ready_rd", readdataM, 32'h00008011);
    check("idle_ready_req", bus_req, 1'b0);
    bus_ready = 1'b0;
    @(negedge clk);

    memreadM = 1'b1; funct3M = 3'b010; addrM = 32'h300; bus_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check("rst_mid_busy", bus_req, 1'b1);
    reset = 1'b0; #1;
    check("rst_mid_req", bus_req, 1'b0);
    check("rst_mid_rd", readdataM, 32'h0);
    check("rst_mid_addr", bus_addr, 32'h0);
    check("rst_mid_be", bus_be, 4'h0);
    memreadM = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    access(1, 0, 3'b010, 32'h300, 32'h0, 32'h0BADF00D, 0);
    check("post_rst_stalls", stalls, 2);
    check("post_rst_data", readdataM, 32'h0BADF00D);
    @(negedge clk);

    access(1, 0, 3'b010, 32'h200, 32'h0, 32'h55555555, 99);
    check("to_stalls", stalls, 5);
    check("to_buserr", buserrM, 1'b1);
    check("to_rd_zero", readdataM, 32'h0);
    @(negedge clk); #1;
    check("to_pulse", buserrM, 1'b0);
    check("to_idle_stall", stallM, 1'b0);
    check("to_idle_req", bus_req, 1'b0);
    @(negedge clk);

    access(1, 0, 3'b010, 32'h204, 32'h0, 32'hA5A5A5A5, 0);
    check("after_to_data", readdataM, 32'hA5A5A5A5);
    check("after_to_err", buserrM, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
